sbqm_teller_dispatch: RTL and testbench
=======================================

Name: sbqm_teller_dispatch

Overview:
Synchronous queue controller for the smart bank queue management system. Counts waiting customers from a single-cycle arrival pulse and issues ticket numbers. Shares the queue among T teller windows using round-robin arbitration. Drives the call display (window, ticket) and an optional estimated-wait output.

Parameters:
N, 3, queue count width; capacity 2**N-1 customers
T, 4, number of teller windows (2..8)
TW, 8, ticket number width; wraps modulo 2**TW
HOLD_CYC, 8, cycles a call stays on the display after a grant (>=1)
SVC, 5, per-customer service time units used for the wait estimate

Ports:
clk  in  1  rising-edge clock
rst  in  1  reset, asynchronous, active-high
arrive  in  1  one-cycle pulse per customer entering (pre-synchronized)
teller_req  in  T  level; bit i high = window i free and requesting next customer
grant  out  T  one-hot, one-cycle pulse to the selected window
call_valid  out  1  high while a call is displayed
call_win  out  clog2(T)  index of the window being called
call_ticket  out  TW  ticket number being called
q_count  out  N  customers waiting
q_full  out  1  q_count == 2**N-1
q_empty  out  1  q_count == 0
overflow  out  1  one-cycle pulse when an arrival is dropped
wait_est  out  N+8  q_count*SVC (see Optional Feature)

Behaviour:
- Reset (async, immediate): state IDLE; q_count=0; next_ticket=0; serve_ticket=0; rr_ptr=0; hold_cnt=0.
- Reset outputs: grant=0, call_valid=0, call_win=0, call_ticket=0, overflow=0, wait_est=0, q_empty=1, q_full=0.
- Reset mid-call aborts the call. No grant is reissued.
- Arrival handling:
  - arrive while not full: q_count+1, next_ticket+1 (wrap).
  - arrive while full: q_count unchanged, next_ticket unchanged, overflow pulses for 1 cycle.
- FSM states: IDLE, GRANT, HOLD.
  - IDLE: if q_count>0 (registered value) and teller_req!=0 -> GRANT. Otherwise stay in IDLE.
  - GRANT (1 cycle):
    - Pick the first requesting window scanning rr_ptr, rr_ptr+1, ... mod T.
    - grant[i]=1 for this cycle only.
    - call_win<=i; call_ticket<=serve_ticket; serve_ticket+1 (wrap).
    - q_count-1; rr_ptr<=(i+1) mod T; hold_cnt<=HOLD_CYC-1.
    - Next state HOLD.
  - HOLD: call_valid=1. Decrement hold_cnt each cycle; at 0 -> IDLE.
  - call_valid is low in IDLE and GRANT. call_win and call_ticket retain their last values.
- teller_req is ignored outside IDLE. A window must drop its req after receiving grant; a req still high in the next IDLE is treated as a new request.
- Simultaneous arrive and GRANT decrement: net q_count unchanged. If the queue is full, this arrival is accepted (no overflow), because the decrement frees a slot in the same cycle.
- Arrival into an empty queue with a req pending: IDLE sees q_count>0 on the following cycle. Minimum arrive-to-grant latency is 2 cycles.
- Ticket invariant: serve_ticket never passes next_ticket. This follows from q_count>0 gating.
- Widths: all ticket arithmetic is modulo 2**TW. q_count never wraps.

Optional Feature:
SBQM_WAIT_EST_EN
- Defined: wait_est is registered and equals q_count*SVC, computed at full N+8 width with no truncation. It updates one cycle after q_count changes and resets to 0.
- Undefined: wait_est is tied to 0 and no multiplier is synthesized.

Test Plan:
- Reset then 3 arrive pulses, no req -> q_count=3, q_empty=0, grant never asserted, next_ticket=3.
- q_count=3, teller_req=4'b1010 held -> grant=4'b0010, call_ticket=0, call_win=1, call_valid high for exactly 8 cycles. Next grant=4'b1000, call_ticket=1, call_win=3.
- Fill to 7 (N=3), one more arrive -> overflow one-cycle pulse, q_count stays 7, q_full=1. Arrive coincident with GRANT at 7 -> q_count=7, no overflow.
- q_count=0, teller_req=4'b0001, single arrive at cycle k -> grant=4'b0001 at cycle k+2, q_count returns to 0.
- Assert rst during HOLD -> call_valid, grant, q_count, call_ticket all 0 immediately; after release the next grant shows ticket 0.
- With SBQM_WAIT_EST_EN, q_count=4, SVC=5 -> wait_est=20. Without the macro -> wait_est=0.

Source files
------------

// File: rtl/sbqm_teller_dispatch.sv
// Bank queue controller: ticketing, round-robin teller dispatch, call display.
// Optional registered wait estimate enabled by defining SBQM_WAIT_EST_EN.
module sbqm_teller_dispatch #(
  parameter int N        = 3,
  parameter int T        = 4,
  parameter int TW       = 8,
  parameter int HOLD_CYC = 8,
  parameter int SVC      = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 arrive,
  input  logic [T-1:0]         teller_req,
  output logic [T-1:0]         grant,
  output logic                 call_valid,
  output logic [$clog2(T)-1:0] call_win,
  output logic [TW-1:0]        call_ticket,
  output logic [N-1:0]         q_count,
  output logic                 q_full,
  output logic                 q_empty,
  output logic                 overflow,
  output logic [N+7:0]         wait_est
);

  localparam int WW  = $clog2(T);
  localparam int HW  = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam int WEW = N + 8;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    HOLD
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    q_count_q, q_count_d;
  logic [TW-1:0]   next_ticket_q, next_ticket_d;
  logic [TW-1:0]   serve_ticket_q, serve_ticket_d;
  logic [WW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [WW-1:0]   pick_q, pick_d;
  logic [T-1:0]    grant_q, grant_d;
  logic            call_valid_q, call_valid_d;
  logic [WW-1:0]   call_win_q, call_win_d;
  logic [TW-1:0]   call_ticket_q, call_ticket_d;
  logic            overflow_q, overflow_d;

  logic            full;
  logic            inc;
  logic            dec;
  logic            arb_found;
  logic [WW-1:0]   arb_idx;

  // First requester at or after rr_ptr, wrapping modulo T
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int k = 0; k < T; k++) begin
      if (!arb_found && teller_req[(int'(rr_ptr_q) + k) % T]) begin
        arb_found = 1'b1;
        arb_idx   = WW'((int'(rr_ptr_q) + k) % T);
      end
    end
  end

  assign full = &q_count_q;
  assign dec  = (state_q == GRANT);
  // A grant frees a slot in the same cycle, so a full queue still accepts
  assign inc  = arrive && (!full || dec);

  always_comb begin
    state_d        = state_q;
    q_count_d      = q_count_q;
    next_ticket_d  = next_ticket_q;
    serve_ticket_d = serve_ticket_q;
    rr_ptr_d       = rr_ptr_q;
    hold_cnt_d     = hold_cnt_q;
    pick_d         = pick_q;
    grant_d        = '0;
    call_valid_d   = call_valid_q;
    call_win_d     = call_win_q;
    call_ticket_d  = call_ticket_q;
    overflow_d     = arrive && full && !dec;

    if (inc) next_ticket_d = next_ticket_q + TW'(1);

    unique case ({inc, dec})
      2'b10:   q_count_d = q_count_q + N'(1);
      2'b01:   q_count_d = q_count_q - N'(1);
      default: q_count_d = q_count_q;
    endcase

    unique case (state_q)
      IDLE: begin
        if (q_count_q != '0 && arb_found) begin
          state_d = GRANT;
          pick_d  = arb_idx;
          grant_d = T'(1) << arb_idx;
        end
      end
      GRANT: begin
        state_d        = HOLD;
        call_win_d     = pick_q;
        call_ticket_d  = serve_ticket_q;
        serve_ticket_d = serve_ticket_q + TW'(1);
        rr_ptr_d       = WW'((int'(pick_q) + 1) % T);
        hold_cnt_d     = HW'(HOLD_CYC - 1);
        call_valid_d   = 1'b1;
      end
      HOLD: begin
        if (hold_cnt_q == '0) begin
          state_d      = IDLE;
          call_valid_d = 1'b0;
        end else begin
          hold_cnt_d = hold_cnt_q - HW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      q_count_q      <= '0;
      next_ticket_q  <= '0;
      serve_ticket_q <= '0;
      rr_ptr_q       <= '0;
      hold_cnt_q     <= '0;
      pick_q         <= '0;
      grant_q        <= '0;
      call_valid_q   <= 1'b0;
      call_win_q     <= '0;
      call_ticket_q  <= '0;
      overflow_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      q_count_q      <= q_count_d;
      next_ticket_q  <= next_ticket_d;
      serve_ticket_q <= serve_ticket_d;
      rr_ptr_q       <= rr_ptr_d;
      hold_cnt_q     <= hold_cnt_d;
      pick_q         <= pick_d;
      grant_q        <= grant_d;
      call_valid_q   <= call_valid_d;
      call_win_q     <= call_win_d;
      call_ticket_q  <= call_ticket_d;
      overflow_q     <= overflow_d;
    end
  end

`ifdef SBQM_WAIT_EST_EN
  logic [WEW-1:0] wait_est_q, wait_est_d;

  always_comb begin
    wait_est_d = WEW'(q_count_q) * WEW'(SVC);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wait_est_q <= '0;
    else     wait_est_q <= wait_est_d;
  end

  assign wait_est = wait_est_q;
`else
  assign wait_est = '0;
`endif

  assign grant       = grant_q;
  assign call_valid  = call_valid_q;
  assign call_win    = call_win_q;
  assign call_ticket = call_ticket_q;
  assign q_count     = q_count_q;
  assign q_full      = full;
  assign q_empty     = (q_count_q == '0);
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_sbqm_teller_dispatch.sv
// Directed bench for sbqm_teller_dispatch with default parameters.
// Covers ticketing, round-robin dispatch, overflow, latency and reset abort.
module tb_sbqm_teller_dispatch;

  logic       clk = 1'b0;
  logic       rst;
  logic       arrive;
  logic [3:0] teller_req;
  logic [3:0] grant;
  logic       call_valid;
  logic [1:0] call_win;
  logic [7:0] call_ticket;
  logic [2:0] q_count;
  logic       q_full;
  logic       q_empty;
  logic       overflow;
  logic [10:0] wait_est;

  int n_run  = 0;
  int n_fail = 0;
  int n;
  logic saw_grant;

  sbqm_teller_dispatch dut (
    .clk         (clk),
    .rst         (rst),
    .arrive      (arrive),
    .teller_req  (teller_req),
    .grant       (grant),
    .call_valid  (call_valid),
    .call_win    (call_win),
    .call_ticket (call_ticket),
    .q_count     (q_count),
    .q_full      (q_full),
    .q_empty     (q_empty),
    .overflow    (overflow),
    .wait_est    (wait_est)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input string tag);
    int c = 0;
    while (grant == 4'b0 && c < 30) begin
      tick();
      c++;
    end
    chk({tag, "_seen"}, 32'(grant != 4'b0), 1);
  endtask

  task automatic hold_check(input string tag, input int win, input int tkt);
    int c = 0;
    tick();
    chk({tag, "_win"}, 32'(call_win), win);
    chk({tag, "_tkt"}, 32'(call_ticket), tkt);
    while (call_valid && c < 30) begin
      c++;
      tick();
    end
    chk({tag, "_len"}, c, 8);
  endtask

  task automatic wait_idle;
    int c = 0;
    while (call_valid && c < 30) begin
      c++;
      tick();
    end
  endtask

  initial begin
    rst        = 1'b1;
    arrive     = 1'b0;
    teller_req = 4'b0;
    #12;
    chk("rst_grant", 32'(grant), 0);
    chk("rst_valid", 32'(call_valid), 0);
    chk("rst_win", 32'(call_win), 0);
    chk("rst_tkt", 32'(call_ticket), 0);
    chk("rst_qcnt", 32'(q_count), 0);
    chk("rst_empty", 32'(q_empty), 1);
    chk("rst_full", 32'(q_full), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_west", 32'(wait_est), 0);
    rst = 1'b0;
    tick();

    saw_grant = 1'b0;
    repeat (3) begin
      arrive = 1'b1;
      tick();
      saw_grant |= |grant;
    end
    arrive = 1'b0;
    tick();
    saw_grant |= |grant;
    chk("arr3_qcnt", 32'(q_count), 3);
    chk("arr3_empty", 32'(q_empty), 0);
    chk("arr3_nogrant", 32'(saw_grant), 0);

    teller_req = 4'b1010;
    wait_grant("g1");
    chk("g1_onehot", 32'(grant), 4'b0010);
    hold_check("h1", 1, 0);
    wait_grant("g2");
    chk("g2_onehot", 32'(grant), 4'b1000);
    teller_req = 4'b0;
    hold_check("h2", 3, 1);
    chk("h2_qcnt", 32'(q_count), 1);

    arrive = 1'b1;
    repeat (6) tick();
    chk("fill_qcnt", 32'(q_count), 7);
    chk("fill_full", 32'(q_full), 1);
    chk("fill_noovf", 32'(overflow), 0);
    tick();
    chk("ovf_pulse", 32'(overflow), 1);
    chk("ovf_qcnt", 32'(q_count), 7);
    arrive = 1'b0;
    tick();
    chk("ovf_clear", 32'(overflow), 0);

    teller_req = 4'b0001;
    tick();
    chk("g3_onehot", 32'(grant), 4'b0001);
    arrive     = 1'b1;
    teller_req = 4'b0;
    tick();
    arrive = 1'b0;
    chk("coin_qcnt", 32'(q_count), 7);
    chk("coin_noovf", 32'(overflow), 0);
    chk("coin_tkt", 32'(call_ticket), 2);
    chk("coin_win", 32'(call_win), 0);
    wait_idle();

    teller_req = 4'b0001;
    n = 0;
    while (!(q_empty && !call_valid && grant == 4'b0) && n < 400) begin
      tick();
      n++;
    end
    chk("drain_empty", 32'(q_empty), 1);
    chk("drain_tkt", 32'(call_ticket), 9);

    arrive = 1'b1;
    tick();
    arrive = 1'b0;
    chk("lat_k1_grant", 32'(grant), 0);
    chk("lat_k1_qcnt", 32'(q_count), 1);
    tick();
    chk("lat_k2_grant", 32'(grant), 4'b0001);
    tick();
    teller_req = 4'b0;
    chk("lat_qcnt", 32'(q_count), 0);
    chk("lat_tkt", 32'(call_ticket), 10);
    wait_idle();

    repeat (4) begin
      arrive = 1'b1;
      tick();
    end
    arrive = 1'b0;
    tick();
    chk("west_qcnt", 32'(q_count), 4);
`ifdef SBQM_WAIT_EST_EN
    chk("west_val", 32'(wait_est), 20);
`else
    chk("west_val", 32'(wait_est), 0);
`endif

    teller_req = 4'b0001;
    wait_grant("g5");
    teller_req = 4'b0;
    tick();
    chk("g5_valid", 32'(call_valid), 1);
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(call_valid), 0);
    chk("arst_grant", 32'(grant), 0);
    chk("arst_qcnt", 32'(q_count), 0);
    chk("arst_tkt", 32'(call_ticket), 0);
    rst = 1'b0;
    arrive = 1'b1;
    tick();
    arrive = 1'b0;
    teller_req = 4'b0001;
    wait_grant("g6");
    chk("g6_onehot", 32'(grant), 4'b0001);
    teller_req = 4'b0;
    tick();
    chk("g6_tkt", 32'(call_ticket), 0);
    chk("g6_win", 32'(call_win), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
